fir_mac_sequencer: RTL and testbench
====================================

// Module: fir_mac_sequencer
// PURPOSE
//  Time-multiplexed controller for a single-MAC lowpass FIR. It accepts one input
//  sample, stores it in an internal circular history, and walks the coefficient ROM
//  (16-bit, 1-cycle registered read) one address per cycle, accumulating coef*sample.
//  It then rounds and saturates the result to 16 bits and presents it on a
//  valid/ready output.
//  Sits between the sample source and the downstream filter consumer; owns the
//  coefficient ROM address bus.
// PARAMETERS
//  NTAPS     60  number of taps; ROM addresses 0..NTAPS-1 are used (NTAPS <= 2**ADDR_W)
//  DATA_W    16  input/output sample width, signed two's complement
//  COEF_W    16  ROM coefficient width, signed Q1.15
//  ADDR_W     7  ROM address width
//  ACC_W     40  accumulator width, signed (>= DATA_W+COEF_W+clog2(NTAPS))
//  OUT_SHIFT 15  right shift applied to the accumulator before output
// PORTS
//  clock        in   1       rising-edge clock for all state
//  reset        in   1       synchronous, active-high
//  in_data      in   DATA_W  input sample
//  in_valid     in   1       in_data valid
//  in_ready     out  1       sequencer can accept a sample (high only in IDLE)
//  rom_address  out  ADDR_W  coefficient ROM address
//  rom_q        in   COEF_W  ROM data; valid 1 cycle after rom_address
//  out_data     out  DATA_W  filtered sample
//  out_valid    out  1       out_data valid; held until out_ready
//  out_ready    in   1       consumer accepts out_data
//  busy         out  1       high in any state other than IDLE
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high.
//  Reset values:
//   - state=IDLE, out_valid=0, out_data=0, rom_address=0, busy=0
//   - wr_ptr=0, acc=0, all NTAPS history entries=0
//   - in_ready=0 while reset is high
//  Reset mid-operation aborts the current computation; the partial result is discarded.
//  FSM: IDLE -> MAC -> DRAIN -> ROUND -> OUT -> IDLE.
//   IDLE : in_ready=1. On in_valid&&in_ready (cycle T): hist[wr_ptr]<=in_data, acc<=0,
//          k<=0, go to MAC.
//   MAC  : cycles T+1..T+NTAPS. rom_address=k. Sample hist[(wr_ptr-k) mod NTAPS] is
//          registered alongside the address; the valid bit is delayed 1 cycle to align
//          with rom_q. Product is sign-extended to ACC_W and added one cycle later.
//          Modulo index wraps from 0 to NTAPS-1 (no power-of-2 requirement).
//          After k==NTAPS-1, go to DRAIN.
//   DRAIN: one cycle; the last product is accumulated. rom_address returns to 0.
//   ROUND: out_data <= sat(( acc + 2**(OUT_SHIFT-1) ) >>> OUT_SHIFT), clamped to
//          [-2**(DATA_W-1), 2**(DATA_W-1)-1]; out_valid <= 1.
//   OUT  : out_valid is high from cycle T+NTAPS+3. out_data and out_valid are stable
//          until out_ready. On handshake: out_valid<=0,
//          wr_ptr <= (wr_ptr==NTAPS-1) ? 0 : wr_ptr+1, go to IDLE.
//  in_valid outside IDLE is ignored; the sample is not consumed.
//  Throughput: one sample per NTAPS+4 cycles when out_ready is tied high.
//  k=0 multiplies the newest sample; k=j multiplies the sample j inputs older.
// TESTING
//  1 Impulse: after reset, in 16'h7FFF then NTAPS zeros -> out sequence equals ROM
//    coefs: 26, 20, 6, -15, ... (tap 29 = 4911), then 0 after NTAPS samples.
//  2 Latency: accept at cycle T with out_ready=1 -> out_valid first high at T+63
//    (NTAPS=60); in_ready low from T+1 until the cycle after the out handshake.
//  3 Backpressure: hold out_ready=0 for 10 cycles while driving in_valid=1 ->
//    out_data/out_valid stable, in_ready=0, no extra sample consumed.
//  4 Saturation: bench ROM model returns 16'h7FFF for all taps, feed 60x 16'h7FFF
//    -> out_data=16'h7FFF; with 16'h8000 inputs -> out_data=16'h8000.
//  5 Reset mid-MAC: assert reset at T+20 for 1 cycle -> next cycle out_valid=0,
//    busy=0, rom_address=0; a following impulse reproduces test 1 exactly
//    (history cleared).
//  6 Wrap: stream 130 random samples vs golden model -> bit-exact across wr_ptr wrap.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// Single-MAC FIR sequencer: one sample in, NTAPS coefficient reads, one rounded/saturated sample out.
// Output valid NTAPS+3 cycles after accept; out_valid/out_data hold until out_ready, and no input is taken meanwhile.
module fir_mac_sequencer #(
    parameter int NTAPS     = 60,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int ADDR_W    = 7,
    parameter int ACC_W     = 40,
    parameter int OUT_SHIFT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [COEF_W-1:0] rom_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int PTR_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int PROD_W = DATA_W + COEF_W;

    typedef enum logic [2:0] {IDLE, MAC, DRAIN, ROUND, OUT} state_t;

    state_t                   state;
    logic [DATA_W-1:0]        hist [NTAPS];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_idx;
    logic signed [DATA_W-1:0] samp;
    logic                     samp_vld;
    logic [ACC_W-1:0]         acc;

    logic signed [PROD_W-1:0] prod;
    logic [ACC_W-1:0]         acc_sum;
    logic [ACC_W-1:0]         rnd;
    logic signed [ACC_W-1:0]  shifted;
    logic [DATA_W-1:0]        sat_val;

    // samp is registered on the same edge the ROM latches the address, so it lines up with rom_q
    assign prod    = samp * $signed(rom_q);
    assign acc_sum = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign rnd     = acc + (ACC_W'(1) << (OUT_SHIFT-1));
    assign shifted = $signed(rnd) >>> OUT_SHIFT;

    always_comb begin
        sat_val = shifted[DATA_W-1:0];
        if (!(&shifted[ACC_W-1:DATA_W-1] || ~|shifted[ACC_W-1:DATA_W-1])) begin
            sat_val = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    assign in_ready = (state == IDLE) && !reset;
    assign busy     = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_data    <= '0;
            rom_address <= '0;
            wr_ptr      <= '0;
            rd_idx      <= '0;
            acc         <= '0;
            samp        <= '0;
            samp_vld    <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                hist[i] <= '0;
            end
        end else begin
            samp_vld <= (state == MAC);
            if (state == MAC) begin
                samp <= hist[rd_idx];
            end
            if (samp_vld) begin
                acc <= acc_sum;
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hist[wr_ptr] <= in_data;
                        acc          <= '0;
                        rom_address  <= '0;
                        rd_idx       <= wr_ptr;
                        state        <= MAC;
                    end
                end
                MAC: begin
                    // walk backwards through the history, newest sample first
                    rd_idx <= (rd_idx == '0) ? PTR_W'(NTAPS-1) : rd_idx - PTR_W'(1);
                    if (rom_address == ADDR_W'(NTAPS-1)) begin
                        rom_address <= '0;
                        state       <= DRAIN;
                    end else begin
                        rom_address <= rom_address + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state <= ROUND;
                end
                ROUND: begin
                    out_data  <= sat_val;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        wr_ptr    <= (wr_ptr == PTR_W'(NTAPS-1)) ? '0 : wr_ptr + PTR_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: impulse table, latency/throughput, backpressure, saturation,
// mid-MAC reset and a random stream compared against an arithmetic convolution model.
module tb_fir_mac_sequencer;

    localparam int NTAPS = 60;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  rom_address;
    logic [15:0] rom_q;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    fir_mac_sequencer dut (
        .clock       (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int coef [128];
    logic sat_rom = 1'b0;
    int cyc = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rom_q <= sat_rom ? 16'h7FFF : 16'(coef[rom_address]);
    end

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_leak = 0;
    logic [15:0] hq [$];

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
    } vec_t;
    vec_t tbl [NTAPS+1];

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    // Direct convolution over the last NTAPS inputs, then round-half-up and clamp.
    function automatic logic [15:0] model_step(input logic [15:0] d);
        longint acc, c, x;
        hq.push_back(d);
        if (hq.size() > NTAPS) void'(hq.pop_front());
        acc = 0;
        for (int j = 0; j < NTAPS; j++) begin
            if (j < hq.size()) begin
                c = sat_rom ? 64'sd32767 : longint'(coef[j]);
                x = longint'($signed(hq[hq.size()-1-j]));
                acc += c * x;
            end
        end
        acc = (acc + 16384) >>> 15;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        return acc[15:0];
    endfunction

    task automatic xfer(input logic [15:0] d, output logic [15:0] y,
                        output int lat, output int t_acc);
        int g;
        g = 0;
        while (!in_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        in_data  = d;
        in_valid = 1'b1;
        t_acc    = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 300) begin
            if (in_ready) rdy_leak++;
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("output_timeout", 0, 1);
        y = out_data;
        if (out_ready) @(negedge clk);
    endtask

    task automatic run_impulse(input string tag);
        logic [15:0] y, e;
        int lat, t, tprev;
        tprev = 0;
        for (int i = 0; i <= NTAPS; i++) begin
            e = model_step(tbl[i].din);
            xfer(tbl[i].din, y, lat, t);
            check({tag, "_out"}, y, tbl[i].dout);
            check({tag, "_model"}, e, tbl[i].dout);
            check({tag, "_latency"}, lat, NTAPS + 3);
            if (i > 0) check({tag, "_period"}, t - tprev, NTAPS + 4);
            tprev = t;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] y, y0, e, d;
        int lat, t;

        for (int i = 0; i < 128; i++) coef[i] = 0;
        coef[0] = 26; coef[1] = 20; coef[2] = 6; coef[3] = -15;
        for (int i = 4; i < 29; i++) coef[i] = i * 170 - 600;
        coef[29] = 4911;
        for (int i = 30; i < NTAPS; i++) coef[i] = coef[NTAPS-1-i];

        for (int i = 0; i <= NTAPS; i++) begin
            tbl[i].din  = (i == 0) ? 16'h7FFF : 16'h0000;
            tbl[i].dout = (i < NTAPS) ? 16'(coef[i]) : 16'h0000;
        end

        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_rom_address", rom_address, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        run_impulse("impulse");
        check("in_ready_low_while_busy", rdy_leak, 0);

        // Backpressure: consumer stalls while the source keeps offering a sample.
        out_ready = 1'b0;
        d = 16'h1234;
        e = model_step(d);
        xfer(d, y0, lat, t);
        check("bp_first_out", y0, e);
        in_data  = 16'h5555;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, y0);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_released", out_valid, 0);
        d = 16'hF00D;
        e = model_step(d);
        xfer(d, y, lat, t);
        check("bp_no_extra_sample", y, e);

        // Saturation with an all-0x7FFF coefficient ROM.
        sat_rom = 1'b1;
        for (int i = 0; i < NTAPS; i++) begin
            e = model_step(16'h7FFF);
            xfer(16'h7FFF, y, lat, t);
            check("sat_pos_model", y, e);
        end
        check("sat_pos_final", y, 16'h7FFF);
        for (int i = 0; i < NTAPS; i++) begin
            e = model_step(16'h8000);
            xfer(16'h8000, y, lat, t);
            check("sat_neg_model", y, e);
        end
        check("sat_neg_final", y, 16'h8000);
        sat_rom = 1'b0;

        // Reset 20 cycles into a computation.
        while (!in_ready) @(negedge clk);
        in_data  = 16'h7FFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        check("mid_mac_busy", busy, 1);
        check("mid_mac_rom_address", rom_address, 19);
        reset = 1'b1;
        #1;
        check("mid_reset_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_out_valid", out_valid, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_rom_address", rom_address, 0);
        hq.delete();
        run_impulse("post_reset");

        // Random stream long enough to wrap the history pointer twice.
        for (int i = 0; i < 130; i++) begin
            d = 16'($urandom);
            e = model_step(d);
            xfer(d, y, lat, t);
            check("random_stream", y, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
